arbiter_fifo2pipeout: RTL and testbench

ARBITER_FIFO2PIPEOUT -- requirements
Module: arbiter_fifo2pipeout

---
 rtl/arbiter_fifo2pipeout_if.sv | 28 ++
 rtl/arbiter_fifo2pipeout.sv | 143 ++++++++++++++
 tb/tb_arbiter_fifo2pipeout.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_fifo2pipeout_if.sv
// Handshake and data bus between the per-core output FIFOs, the readout arbiter
// and the pipe-out FIFO.
interface arbiter_fifo2pipeout_if #(
  parameter int unsigned NUM_CORES = 8
) ();
  logic                      start;
  logic [NUM_CORES-1:0]      core_select;
  logic [9:0]                num_words;
  logic [1:0]                padding_words;
  logic [32*NUM_CORES-1:0]   core_dout;
  logic [NUM_CORES-1:0]      core_valid;
  logic [NUM_CORES-1:0]      core_rd_en;
  logic [31:0]               dout;
  logic                      dout_valid;
  logic                      dout_ready;
  logic                      idle;
  logic                      done;

  modport master (
    output start, core_select, num_words, padding_words, core_dout, core_valid, dout_ready,
    input  core_rd_en, dout, dout_valid, idle, done
  );

  modport slave (
    input  start, core_select, num_words, padding_words, core_dout, core_valid, dout_ready,
    output core_rd_en, dout, dout_valid, idle, done
  );
endinterface

// File: rtl/arbiter_fifo2pipeout.sv
// Readout arbiter: walks the selected core FIFOs in index order and streams
// num_words per core (data then zero padding) into a single output register.
module arbiter_fifo2pipeout #(
  parameter int unsigned NUM_CORES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  arbiter_fifo2pipeout_if.slave bus
);
  localparam int unsigned AW = 4;
  localparam int unsigned WW = 10;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, CHECK_ADDR, TRANSFER, PAD} state_t;

  state_t               state, state_nxt;
  logic [AW-1:0]        addr, addr_nxt;
  logic [WW-1:0]        wcnt, wcnt_nxt;
  logic [NUM_CORES-1:0] sel_q;
  logic [WW-1:0]        nw_q;
  logic [1:0]           pad_q;
  logic [DW-1:0]        dout_q, dout_nxt;
  logic                 dv_q, dv_nxt;
  logic                 idle_q, done_q;
  logic [NUM_CORES-1:0] rd_en;
  logic                 latch;
  logic [WW-1:0]        data_words;
  logic                 can_load, in_range;
  logic [DW-1:0]        head;
  logic                 cur_valid, cur_sel;

  assign data_words = (nw_q > WW'(pad_q)) ? nw_q - WW'(pad_q) : '0;
  assign can_load   = ~dv_q | bus.dout_ready;
  assign in_range   = 32'(addr) < NUM_CORES;

  // Mux of the currently addressed core; out-of-range addresses read as idle.
  always_comb begin
    head      = '0;
    cur_valid = 1'b0;
    cur_sel   = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (32'(addr) == i) begin
        head      = bus.core_dout[DW*i +: DW];
        cur_valid = bus.core_valid[i];
        cur_sel   = sel_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    wcnt_nxt  = wcnt;
    dout_nxt  = dout_q;
    dv_nxt    = dv_q;
    rd_en     = '0;
    latch     = 1'b0;
    // An accepted word leaves the register empty unless a new one loads below.
    if (dv_q && bus.dout_ready) dv_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          latch     = 1'b1;
          addr_nxt  = '0;
          wcnt_nxt  = '0;
          state_nxt = CHECK_ADDR;
        end
      end
      CHECK_ADDR: begin
        if (!in_range) begin
          state_nxt = IDLE;
        end else if (cur_sel && nw_q != '0) begin
          wcnt_nxt  = '0;
          state_nxt = TRANSFER;
        end else begin
          addr_nxt = addr + AW'(1);
        end
      end
      TRANSFER: begin
        if (wcnt < data_words) begin
          if (cur_valid && can_load) begin
            rd_en    = NUM_CORES'(1) << addr;
            dout_nxt = head;
            dv_nxt   = 1'b1;
            wcnt_nxt = wcnt + WW'(1);
          end
        end else begin
          state_nxt = PAD;
        end
      end
      PAD: begin
        if (wcnt < nw_q) begin
          if (can_load) begin
            dout_nxt = '0;
            dv_nxt   = 1'b1;
            wcnt_nxt = wcnt + WW'(1);
          end
        end else begin
          addr_nxt  = addr + AW'(1);
          state_nxt = CHECK_ADDR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr   <= '0;
      wcnt   <= '0;
      sel_q  <= '0;
      nw_q   <= '0;
      pad_q  <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      idle_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      addr   <= addr_nxt;
      wcnt   <= wcnt_nxt;
      dout_q <= dout_nxt;
      dv_q   <= dv_nxt;
      idle_q <= (state_nxt == IDLE);
      done_q <= (state == CHECK_ADDR) && !in_range;
      if (latch) begin
        sel_q <= bus.core_select;
        nw_q  <= bus.num_words;
        pad_q <= bus.padding_words;
      end
    end
  end

  assign bus.core_rd_en = rd_en;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.idle       = idle_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_arbiter_fifo2pipeout.sv
// Bench for arbiter_fifo2pipeout: FIFO models per core, an expected word queue
// built from the pass configuration, and a per-cycle output monitor.
module tb_arbiter_fifo2pipeout;
  localparam int unsigned NC = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arbiter_fifo2pipeout_if #(.NUM_CORES(NC)) bus ();
  arbiter_fifo2pipeout #(.NUM_CORES(NC)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0]   mem [NC][16];
  int            rp [NC];
  int            wp [NC];
  int            pops_seen [NC];
  int            pops_exp [NC];
  logic [NC-1:0] pend;
  logic [31:0]   exp_q [$];
  logic [31:0]   acc_log [$];
  int            done_cnt, busy_cycles, cyc;
  int            checks = 0;
  int            errors = 0;
  logic          gate_en;
  logic          prev_stall;
  logic [31:0]   prev_dout;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < int'(NC); i++) begin
      bus.core_valid[i] = (rp[i] < wp[i]) && (!gate_en || (cyc % 2 == 0));
      bus.core_dout[32*i +: 32] = (rp[i] < wp[i]) ? mem[i][rp[i]] : 32'hDEAD_0000;
    end
  endtask

  // FIFO model: pops decided at the previous negedge take effect at this edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < int'(NC); i++)
      if (pend[i] && rp[i] < wp[i]) rp[i]++;
    pend = '0;
    cyc++;
    refresh();
  end

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.core_rd_en != '0) begin
        chk("rd_onehot", 32'($onehot(bus.core_rd_en)), 32'd1);
        for (int i = 0; i < int'(NC); i++) begin
          if (bus.core_rd_en[i]) begin
            pops_seen[i]++;
            chk("rd_allowed", 32'(pops_seen[i] <= pops_exp[i]), 32'd1);
            chk("rd_valid", 32'(bus.core_valid[i]), 32'd1);
          end
        end
      end
      pend = bus.core_rd_en;
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.dout_valid), 32'd1);
        chk("hold_dout", bus.dout, prev_dout);
      end
      if (bus.dout_valid && bus.dout_ready) begin
        acc_log.push_back(bus.dout);
        if (exp_q.size() == 0) chk("extra_word", bus.dout, 32'hFFFF_FFFF);
        else                   chk("dout", bus.dout, exp_q.pop_front());
      end
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_dout  = bus.dout;
      if (bus.done) done_cnt++;
      if (!bus.idle) busy_cycles++;
    end
  end

  // Loads the FIFO models and the expected stream for one pass configuration.
  task automatic setup(input logic [7:0] sel, input logic [9:0] nw, input logic [1:0] pad);
    int dw;
    dw = (int'(nw) > int'(pad)) ? int'(nw) - int'(pad) : 0;
    exp_q.delete();
    acc_log.delete();
    done_cnt = 0;
    busy_cycles = 0;
    for (int i = 0; i < int'(NC); i++) begin
      rp[i] = 0; wp[i] = 0; pops_seen[i] = 0; pops_exp[i] = 0;
      if (sel[i] && nw != 0) begin
        for (int k = 0; k < dw; k++) begin
          mem[i][wp[i]] = 32'h1000 * (i + 1) + k;
          exp_q.push_back(mem[i][wp[i]]);
          wp[i]++;
        end
        for (int k = dw; k < int'(nw); k++) exp_q.push_back(32'h0);
        pops_exp[i] = dw;
      end else begin
        for (int k = 0; k < 2; k++) begin
          mem[i][wp[i]] = 32'hBAD0_0000 | i;
          wp[i]++;
        end
      end
    end
    refresh();
  endtask

  task automatic pulse_start(input logic [7:0] sel, input logic [9:0] nw, input logic [1:0] pad);
    bus.core_select = sel; bus.num_words = nw; bus.padding_words = pad; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.core_select = ~sel; bus.num_words = 10'd7; bus.padding_words = 2'd0;
  endtask

  task automatic run_pass(input logic [7:0] sel, input logic [9:0] nw, input logic [1:0] pad,
                          input int ready_low_at, input bit busy_starts);
    int n;
    setup(sel, nw, pad);
    pulse_start(sel, nw, pad);
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      bus.dout_ready = !(ready_low_at >= 0 && n >= ready_low_at && n < ready_low_at + 5);
      bus.start = busy_starts && (n % 7 == 3) && !bus.idle;
    end
    bus.start = 1'b0;
    bus.dout_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.dout_valid) && n < 50) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("idle_end", 32'(bus.idle), 32'd1);
    for (int i = 0; i < int'(NC); i++) chk("pop_count", 32'(pops_seen[i]), 32'(pops_exp[i]));
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b0; cyc = 0; pend = '0; gate_en = 1'b0; prev_stall = 1'b0;
    bus.start = 1'b0; bus.core_select = '0; bus.num_words = '0; bus.padding_words = '0;
    bus.dout_ready = 1'b1; bus.core_valid = '0; bus.core_dout = '0;
    setup(8'h00, 10'd0, 2'd0);
    #1 rst = 1'b1;
    #3;
    chk("rst_idle", 32'(bus.idle), 32'd1);
    chk("rst_dv", 32'(bus.dout_valid), 32'd0);
    chk("rst_dout", bus.dout, 32'd0);
    chk("rst_rd_en", 32'(bus.core_rd_en), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two cores, one pad word each.
    run_pass(8'h05, 10'd4, 2'd1, -1, 1'b0);
    chk("p1_len", 32'(acc_log.size()), 32'd8);
    if (acc_log.size() == 8) begin
      chk("p1_w0", acc_log[0], 32'h0000_1000);
      chk("p1_w2", acc_log[2], 32'h0000_1002);
      chk("p1_w3", acc_log[3], 32'h0);
      chk("p1_w4", acc_log[4], 32'h0000_3000);
      chk("p1_w7", acc_log[7], 32'h0);
    end
    chk("p1_pops0", 32'(pops_seen[0]), 32'd3);
    chk("p1_pops2", 32'(pops_seen[2]), 32'd3);

    // Empty selection: address scan only.
    run_pass(8'h00, 10'd4, 2'd1, -1, 1'b0);
    chk("p2_len", 32'(acc_log.size()), 32'd0);
    chk("p2_busy", 32'(busy_cycles), 32'd9);

    // Padding exceeds num_words: zeros only.
    run_pass(8'h80, 10'd2, 2'd3, -1, 1'b0);
    chk("p3_len", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2) begin
      chk("p3_w0", acc_log[0], 32'h0);
      chk("p3_w1", acc_log[1], 32'h0);
    end
    chk("p3_pops7", 32'(pops_seen[7]), 32'd0);

    // Back-pressure for 5 cycles in the middle of a transfer.
    run_pass(8'h02, 10'd8, 2'd0, 6, 1'b0);
    chk("p4_len", 32'(acc_log.size()), 32'd8);
    if (acc_log.size() == 8) chk("p4_w7", acc_log[7], 32'h0000_2007);

    // Source stalls every other cycle, start pulses while busy.
    gate_en = 1'b1;
    run_pass(8'h5A, 10'd5, 2'd2, -1, 1'b1);
    gate_en = 1'b0;
    chk("p5_len", 32'(acc_log.size()), 32'd20);

    // Reset while transferring core 3, then a clean pass.
    setup(8'h08, 10'd10, 2'd0);
    pulse_start(8'h08, 10'd10, 2'd0);
    n = 0;
    while (pops_seen[3] < 3 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("p6_reached", 32'(pops_seen[3] >= 3), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("p6_rst_dv", 32'(bus.dout_valid), 32'd0);
    chk("p6_rst_dout", bus.dout, 32'd0);
    chk("p6_rst_rd_en", 32'(bus.core_rd_en), 32'd0);
    chk("p6_rst_idle", 32'(bus.idle), 32'd1);
    chk("p6_rst_done", 32'(bus.done), 32'd0);
    pend = '0;
    setup(8'h00, 10'd0, 2'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_pass(8'h09, 10'd3, 2'd1, -1, 1'b0);
    chk("p7_len", 32'(acc_log.size()), 32'd6);
    if (acc_log.size() == 6) chk("p7_w3", acc_log[3], 32'h0000_4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
